// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer for the J17 core: strobes IR load, PC update, ALU launch,
// register write-back and stack push/pop. Define SEQ_INSTRET_EN to build the retired-instruction counter.
module exec_sequencer #(
  parameter int MULTI_LAT = 4,
  parameter int SP_W      = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [5:0]      instr_opcode,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_en,
  output logic            alu_start,
  output logic            regwrite_en,
  output logic            stack_push,
  output logic            stack_pop,
  output logic [SP_W-1:0] sp,
  output logic            halted,
  output logic            stack_err,
  output logic [2:0]      state,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_STACK  = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam int              CNT_W     = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MULTI_LAT - 1);
  localparam logic [SP_W-1:0]  SP_FULL   = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [SP_W-1:0]  r_sp;
  logic             r_stack_err;

  logic w_is_halt;
  logic w_is_nop;
  logic w_is_push;
  logic w_is_pop;
  logic w_is_multi;
  logic w_writes_reg;
  logic w_push_ok;
  logic w_pop_ok;

  // Opcode classes: undefined opcodes above MOVI are treated like HLT.
  assign w_is_halt    = (instr_opcode == 6'd26) || (instr_opcode > 6'd29);
  assign w_is_nop     = (instr_opcode == 6'd25);
  assign w_is_push    = (instr_opcode == 6'd27);
  assign w_is_pop     = (instr_opcode == 6'd28);
  assign w_is_multi   = (instr_opcode == 6'd2) || (instr_opcode == 6'd3) ||
                        (instr_opcode == 6'd6) || (instr_opcode == 6'd7) ||
                        (instr_opcode == 6'd12);
  assign w_writes_reg = (instr_opcode <= 6'd14) || (instr_opcode == 6'd24) ||
                        (instr_opcode == 6'd28) || (instr_opcode == 6'd29);

  assign w_push_ok = (r_state == S_STACK) && w_is_push && (r_sp != SP_FULL);
  assign w_pop_ok  = (r_state == S_STACK) && w_is_pop  && (r_sp != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_halt)                  r_state <= S_HALT;
          else if (w_is_nop)              r_state <= S_WB;
          else if (w_is_push || w_is_pop) r_state <= S_STACK;
          else                            r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_multi) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= WAIT_LOAD;
          end else begin
            r_state <= S_WB;
          end
        end
        // Counter is loaded with MULTI_LAT-1 so WAIT lasts exactly MULTI_LAT cycles.
        S_WAIT: begin
          if (r_wait_cnt == '0) r_state <= S_WB;
          else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        S_STACK: begin
          if (w_push_ok) begin
            r_sp    <= r_sp + 1'b1;
            r_state <= S_WB;
          end else if (w_pop_ok) begin
            r_sp    <= r_sp - 1'b1;
            r_state <= S_WB;
          end else begin
            r_stack_err <= 1'b1;
            r_state     <= S_HALT;
          end
        end
        S_WB:     r_state <= run ? S_FETCH : S_IDLE;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign state       = r_state;
  assign ir_load     = (r_state == S_FETCH) && mem_ready;
  assign pc_en       = (r_state == S_WB);
  assign alu_start   = (r_state == S_EXEC);
  assign regwrite_en = (r_state == S_WB) && w_writes_reg;
  assign stack_push  = w_push_ok;
  assign stack_pop   = w_pop_ok;
  assign sp          = r_sp;
  assign halted      = (r_state == S_HALT);
  assign stack_err   = r_stack_err;

`ifdef SEQ_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clock) begin
    if (reset)                 r_instret <= '0;
    else if (r_state == S_WB)  r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = 32'd0;
`endif

endmodule
